store_be_unit: RTL and testbench

STORE_BE_UNIT -- requirements
Module: store_be_unit

---
 rtl/store_be_unit.sv | 207 ++++++++++++++++++++
 tb/tb_store_be_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_be_unit.sv
// Store byte-enable unit: turns a right-justified store into one or two lane-aligned bus write beats.
// Misaligned stores are split or realigned, or rejected with an error pulse.
`ifndef DM_sb
`define DM_sb 4'd1
`endif
`ifndef DM_sh
`define DM_sh 4'd2
`endif
`ifndef DM_sw
`define DM_sw 4'd3
`endif
`ifndef DM_sd
`define DM_sd 4'd4
`endif

module store_be_unit #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned ALLOW_MISALIGN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [3:0]            req_op,
  input  logic [DATA_W-1:0]     req_data,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W/8-1:0]   bus_byteen,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [15:0]           beat_cnt
);

  localparam int unsigned B    = DATA_W / 8;
  localparam int unsigned LG   = $clog2(B);
  localparam int unsigned SZ_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [B-1:0]        bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic                crossing_q, crossing_d;
  logic [B-1:0]        be1_q, be1_d;
  logic [DATA_W-1:0]   wdata1_q, wdata1_d;

  logic [SZ_W-1:0]     size_c;
  logic                illegal_c;
  logic                misalign_c;
  logic                crossing_c;
  logic [LG-1:0]       off_c;
  logic [B-1:0]        lane_mask_c;
  logic [2*B-1:0]      be_wide_c;
  logic [2*DATA_W-1:0] data_wide_c;
  logic [ADDR_W-1:0]   base_addr_c;

  // Request decode: size, legality, and both beats' lanes as one double-width shift.
  always_comb begin
    case (req_op)
      `DM_sb:  size_c = 4'd1;
      `DM_sh:  size_c = 4'd2;
      `DM_sw:  size_c = 4'd4;
      `DM_sd:  size_c = (DATA_W == 64) ? 4'd8 : 4'd0;
      default: size_c = 4'd0;
    endcase
    illegal_c   = (size_c == 4'd0);
    misalign_c  = |(req_addr[3:0] & (size_c - 4'd1));
    off_c       = req_addr[LG-1:0];
    base_addr_c = req_addr & ~ADDR_W'(B - 1);
    lane_mask_c = '0;
    data_wide_c = '0;
    for (int unsigned i = 0; i < B; i++) begin
      if (SZ_W'(i) < size_c) begin
        lane_mask_c[i]        = 1'b1;
        data_wide_c[8*i +: 8] = req_data[8*i +: 8];
      end
    end
    be_wide_c   = {{B{1'b0}}, lane_mask_c} << off_c;
    data_wide_c = data_wide_c << {off_c, 3'b000};
    crossing_c  = |be_wide_c[2*B-1:B];
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    err_valid_d = 1'b0;
    err_code_d  = 2'b00;
    crossing_d  = crossing_q;
    be1_d       = be1_q;
    wdata1_d    = wdata1_q;
    beat_cnt_d  = beat_cnt_q;

    if (bus_valid_q && bus_ready && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal_c) begin
            state_d     = S_ERR;
            err_valid_d = 1'b1;
            err_code_d  = 2'b01;
          end else if (misalign_c && (ALLOW_MISALIGN == 0)) begin
            state_d     = S_ERR;
            err_valid_d = 1'b1;
            err_code_d  = 2'b10;
          end else begin
            state_d     = S_BEAT0;
            bus_valid_d = 1'b1;
            bus_addr_d  = base_addr_c;
            bus_be_d    = be_wide_c[B-1:0];
            bus_wdata_d = data_wide_c[DATA_W-1:0];
            crossing_d  = crossing_c;
            be1_d       = be_wide_c[2*B-1:B];
            wdata1_d    = data_wide_c[2*DATA_W-1:DATA_W];
          end
        end
      end
      S_BEAT0: begin
        if (bus_ready) begin
          if (crossing_q) begin
            state_d     = S_BEAT1;
            bus_addr_d  = bus_addr_q + ADDR_W'(B);
            bus_be_d    = be1_q;
            bus_wdata_d = wdata1_q;
          end else begin
            state_d     = S_IDLE;
            bus_valid_d = 1'b0;
            bus_addr_d  = '0;
            bus_be_d    = '0;
            bus_wdata_d = '0;
          end
        end
      end
      S_BEAT1: begin
        if (bus_ready) begin
          state_d     = S_IDLE;
          bus_valid_d = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      beat_cnt_q  <= '0;
      crossing_q  <= 1'b0;
      be1_q       <= '0;
      wdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      beat_cnt_q  <= beat_cnt_d;
      crossing_q  <= crossing_d;
      be1_q       <= be1_d;
      wdata1_q    <= wdata1_d;
    end
  end

  // Ready is a state decode gated by reset so it reads 1 in the very first cycle after release.
  assign req_ready  = reset && (state_q == S_IDLE);
  assign bus_valid  = bus_valid_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_store_be_unit.sv
// Bench for store_be_unit: three configurations (32-bit, 64-bit, 32-bit strict) against a byte-level model.
`ifndef DM_sb
`define DM_sb 4'd1
`endif
`ifndef DM_sh
`define DM_sh 4'd2
`endif
`ifndef DM_sw
`define DM_sw 4'd3
`endif
`ifndef DM_sd
`define DM_sd 4'd4
`endif

module tb_store_be_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [3];
  logic [31:0] req_addr  [3];
  logic [3:0]  req_op    [3];
  logic [63:0] req_data  [3];
  logic        bus_ready [3];

  logic rdy0, bv0, ev0, rdy1, bv1, ev1, rdy2, bv2, ev2;
  logic [1:0]  ec0, ec1, ec2;
  logic [31:0] ba0, ba1, ba2;
  logic [3:0]  be0, be2;
  logic [7:0]  be1;
  logic [31:0] wd0, wd2;
  logic [63:0] wd1;
  logic [15:0] cnt0, cnt1, cnt2;

  store_be_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy0),
    .req_addr(req_addr[0]), .req_op(req_op[0]), .req_data(req_data[0][31:0]),
    .bus_valid(bv0), .bus_ready(bus_ready[0]), .bus_addr(ba0), .bus_byteen(be0),
    .bus_wdata(wd0), .err_valid(ev0), .err_code(ec0), .beat_cnt(cnt0));

  store_be_unit #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGN(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy1),
    .req_addr(req_addr[1]), .req_op(req_op[1]), .req_data(req_data[1]),
    .bus_valid(bv1), .bus_ready(bus_ready[1]), .bus_addr(ba1), .bus_byteen(be1),
    .bus_wdata(wd1), .err_valid(ev1), .err_code(ec1), .beat_cnt(cnt1));

  store_be_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(0)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(rdy2),
    .req_addr(req_addr[2]), .req_op(req_op[2]), .req_data(req_data[2][31:0]),
    .bus_valid(bv2), .bus_ready(bus_ready[2]), .bus_addr(ba2), .bus_byteen(be2),
    .bus_wdata(wd2), .err_valid(ev2), .err_code(ec2), .beat_cnt(cnt2));

  typedef struct packed {
    logic        rdy;
    logic        bv;
    logic        ev;
    logic [1:0]  ec;
    logic [31:0] ba;
    logic [7:0]  be;
    logic [63:0] wd;
    logic [15:0] cnt;
  } obs_t;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt [3];

  function automatic obs_t get(input int k);
    obs_t o;
    o = '0;
    case (k)
      0: begin
        o.rdy = rdy0; o.bv = bv0; o.ev = ev0; o.ec = ec0; o.ba = ba0;
        o.be = {4'h0, be0}; o.wd = {32'h0, wd0}; o.cnt = cnt0;
      end
      1: begin
        o.rdy = rdy1; o.bv = bv1; o.ev = ev1; o.ec = ec1; o.ba = ba1;
        o.be = be1; o.wd = wd1; o.cnt = cnt1;
      end
      default: begin
        o.rdy = rdy2; o.bv = bv2; o.ev = ev2; o.ec = ec2; o.ba = ba2;
        o.be = {4'h0, be2}; o.wd = {32'h0, wd2}; o.cnt = cnt2;
      end
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: place each store byte at its absolute address, then group by bus word.
  function automatic void model(input int k, input logic [31:0] addr, input logic [3:0] op,
                                input logic [63:0] data, output int nb, output logic [1:0] ec,
                                output logic [1:0][31:0] ba, output logic [1:0][7:0] be,
                                output logic [1:0][63:0] wd);
    int bb;
    int sz;
    int rel;
    int bt;
    int ln;
    logic [31:0] base;
    bb = (k == 1) ? 8 : 4;
    nb = 0; ec = 2'b00; ba = '0; be = '0; wd = '0;
    case (op)
      `DM_sb:  sz = 1;
      `DM_sh:  sz = 2;
      `DM_sw:  sz = 4;
      `DM_sd:  sz = (bb == 8) ? 8 : 0;
      default: sz = 0;
    endcase
    if (sz == 0) begin
      ec = 2'b01;
    end else if (((addr % 32'(sz)) != 0) && (k == 2)) begin
      ec = 2'b10;
    end else begin
      base  = addr - (addr % 32'(bb));
      ba[0] = base;
      ba[1] = base + 32'(bb);
      nb    = 1;
      for (int j = 0; j < sz; j++) begin
        rel = int'(addr % 32'(bb)) + j;
        bt  = rel / bb;
        ln  = rel % bb;
        be[bt][ln] = 1'b1;
        wd[bt][8*ln +: 8] = data[8*j +: 8];
        if (bt == 1) nb = 2;
      end
    end
  endfunction

  task automatic check_idle(input int k, input string tag);
    obs_t o;
    o = get(k);
    check($sformatf("%s.k%0d.valid", tag, k), 64'(o.bv), 64'd0);
    check($sformatf("%s.k%0d.addr", tag, k), 64'(o.ba), 64'd0);
    check($sformatf("%s.k%0d.be", tag, k), 64'(o.be), 64'd0);
    check($sformatf("%s.k%0d.wdata", tag, k), o.wd, 64'd0);
    check($sformatf("%s.k%0d.err", tag, k), 64'(o.ev), 64'd0);
    check($sformatf("%s.k%0d.cnt", tag, k), 64'(o.cnt), 64'(exp_cnt[k]));
  endtask

  // One store through DUT k; every wait is a fixed number of cycles.
  task automatic run(input int k, input logic [31:0] addr, input logic [3:0] op,
                     input logic [63:0] data, input int stall);
    int nb;
    logic [1:0] ec;
    logic [1:0][31:0] ba;
    logic [1:0][7:0] be;
    logic [1:0][63:0] wd;
    obs_t o;
    model(k, addr, op, data, nb, ec, ba, be, wd);
    o = get(k);
    check($sformatf("ready.k%0d", k), 64'(o.rdy), 64'd1);
    req_valid[k] = 1'b1; req_addr[k] = addr; req_op[k] = op; req_data[k] = data;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    if (nb == 0) begin
      o = get(k);
      check($sformatf("err.k%0d.a%h", k, addr), 64'(o.ev), 64'd1);
      check($sformatf("errcode.k%0d.a%h", k, addr), 64'(o.ec), 64'(ec));
      check($sformatf("errnobeat.k%0d", k), 64'(o.bv), 64'd0);
      check($sformatf("errready.k%0d", k), 64'(o.rdy), 64'd0);
      @(posedge clk); #1;
      o = get(k);
      check($sformatf("errpulse.k%0d", k), 64'(o.ev), 64'd0);
      check($sformatf("errdone.k%0d", k), 64'(o.rdy), 64'd1);
    end else begin
      for (int b = 0; b < nb; b++) begin
        for (int s = 0; s <= stall; s++) begin
          o = get(k);
          check($sformatf("bv.k%0d.b%0d.a%h", k, b, addr), 64'(o.bv), 64'd1);
          check($sformatf("ba.k%0d.b%0d.a%h", k, b, addr), 64'(o.ba), 64'(ba[b]));
          check($sformatf("be.k%0d.b%0d.a%h", k, b, addr), 64'(o.be), 64'(be[b]));
          check($sformatf("wd.k%0d.b%0d.a%h", k, b, addr), o.wd, wd[b]);
          check($sformatf("busyrdy.k%0d", k), 64'(o.rdy), 64'd0);
          bus_ready[k] = (s == stall);
          @(posedge clk); #1;
        end
        bus_ready[k] = 1'b0;
        if (exp_cnt[k] < 65535) exp_cnt[k]++;
      end
      o = get(k);
      check($sformatf("done.k%0d", k), 64'(o.rdy), 64'd1);
      check_idle(k, "post");
    end
  endtask

  initial begin
    obs_t o;
    logic [3:0] op;
    logic [31:0] addr;
    int k;
    int r;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_op[i] = '0; req_data[i] = '0;
      bus_ready[i] = 1'b0; exp_cnt[i] = 0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check_idle(i, "rst");
      o = get(i);
      check($sformatf("rstrdy.k%0d", i), 64'(o.rdy), 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      o = get(i);
      check($sformatf("relrdy.k%0d", i), 64'(o.rdy), 64'd1);
    end
    @(posedge clk); #1;

    run(0, 32'h0000_1003, `DM_sw, 64'hAABB_CCDD, 0);
    run(0, 32'h0000_2002, `DM_sh, 64'h1234, 0);
    run(0, 32'h0000_2001, `DM_sh, 64'h1234, 0);
    run(0, 32'hFFFF_FFFE, `DM_sw, 64'h5566_7788, 1);
    run(0, 32'h0000_0010, `DM_sd, 64'h0102_0304_0506_0708, 0);
    run(2, 32'h0000_1001, `DM_sw, 64'h1122_3344, 0);
    run(2, 32'h0000_1001, `DM_sd, 64'h1122_3344, 0);
    run(2, 32'h0000_1004, `DM_sw, 64'h1122_3344, 0);
    run(1, 32'h0000_0010, `DM_sd, 64'h0102_0304_0506_0708, 0);
    run(1, 32'h0000_0016, `DM_sw, 64'hDEAD_BEEF, 0);
    run(0, 32'h0000_3000, `DM_sw, 64'hCAFE_F00D, 5);

    // Reset while a split store is in its second beat.
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_1003; req_op[0] = `DM_sw; req_data[0] = 64'hAABB_CCDD;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; bus_ready[0] = 1'b1;
    @(posedge clk); #1;
    bus_ready[0] = 1'b0;
    o = get(0);
    check("b1.valid", 64'(o.bv), 64'd1);
    check("b1.addr", 64'(o.ba), 64'h1004);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_cnt[i] = 0;
      check_idle(i, "midrst");
      o = get(i);
      check($sformatf("midrstrdy.k%0d", i), 64'(o.rdy), 64'd0);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_idle(0, "after");
    o = get(0);
    check("afterrdy", 64'(o.rdy), 64'd1);

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    op = `DM_sb;
        2, 3:    op = `DM_sh;
        4, 5, 6: op = `DM_sw;
        7, 8:    op = `DM_sd;
        default: op = 4'($urandom_range(5, 15));
      endcase
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF8 | (addr & 32'h7);
      run(k, addr, op, {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
